ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 118 +++++++++++
 tb/tb_ifu_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding fetch FSM with redirect squash.
// Holds one fetched instruction for decode under a valid/ready handshake.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        req_hs;
    logic        capture;

    assign req_hs  = (state_q == REQ) && imem_req_ready_i;
    assign capture = (state_q == WAIT) && imem_rsp_valid_i
                     && !redirect_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect outranks every other event; a request already accepted
    // by memory must have its response drained in DROP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect_valid_i) begin
                    state_d = req_hs ? DROP : REQ;
                end else if (req_hs) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid_i) begin
                    state_d = imem_rsp_valid_i ? REQ : DROP;
                end else if (imem_rsp_valid_i) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid_i || inst_ready_i) begin
                    state_d = REQ;
                end
            end
            DROP: begin
                if (!redirect_valid_i && imem_rsp_valid_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid_o = 1'b0;
        inst_valid_o     = 1'b0;
        unique case (state_q)
            REQ:     imem_req_valid_o = 1'b1;
            HOLD:    inst_valid_o     = 1'b1;
            default: begin
                imem_req_valid_o = 1'b0;
                inst_valid_o     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
        end else begin
            if (redirect_valid_i) begin
                pc_q <= redirect_pc_i & ~32'h3;
            end else if (capture) begin
                pc_q <= pc_q + 32'd4;
            end
            if (capture) begin
                inst_q    <= imem_rsp_data_i;
                inst_pc_q <= pc_q;
            end
        end
    end

    assign imem_req_addr_o = pc_q;
    assign inst_o          = inst_q;
    assign inst_pc_o       = inst_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: handshake, stall, redirect, wrap, reset.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    int total;
    int bad;

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst_n            = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        inst_ready_i     = 1'b0;
        tick();
        tick();
        chk("rst_req_valid", {31'h0, imem_req_valid_o}, 32'h0);
        chk("rst_inst_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_inst_pc", inst_pc_o, 32'h0);
        chk("rst_addr", imem_req_addr_o, 32'h8000_0000);

        rst_n = 1'b1;
        chk("idle_req_valid", {31'h0, imem_req_valid_o}, 32'h0);
        tick();
        chk("req_valid", {31'h0, imem_req_valid_o}, 32'h1);
        chk("req_addr0", imem_req_addr_o, 32'h8000_0000);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        chk("wait_req_valid", {31'h0, imem_req_valid_o}, 32'h0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0000_0013;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("hold_valid", {31'h0, inst_valid_o}, 32'h1);
        chk("hold_inst", inst_o, 32'h0000_0013);
        chk("hold_pc", inst_pc_o, 32'h8000_0000);
        chk("next_addr", imem_req_addr_o, 32'h8000_0004);

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'h0, inst_valid_o}, 32'h1);
            chk("stall_inst", inst_o, 32'h0000_0013);
            chk("stall_pc", inst_pc_o, 32'h8000_0000);
            chk("stall_req", {31'h0, imem_req_valid_o}, 32'h0);
        end
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk("req2_valid", {31'h0, imem_req_valid_o}, 32'h1);
        chk("req2_addr", imem_req_addr_o, 32'h8000_0004);
        chk("req2_inst_valid", {31'h0, inst_valid_o}, 32'h0);

        // redirect while waiting; stale response must vanish
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0102;
        tick();
        redirect_valid_i = 1'b0;
        chk("drop_req", {31'h0, imem_req_valid_o}, 32'h0);
        chk("drop_inst_valid", {31'h0, inst_valid_o}, 32'h0);
        tick();
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hDEAD_BEEF;
        chk("drop2_inst_valid", {31'h0, inst_valid_o}, 32'h0);
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("redir_req", {31'h0, imem_req_valid_o}, 32'h1);
        chk("redir_addr", imem_req_addr_o, 32'h8000_0100);
        chk("redir_no_stale", {31'h0, inst_valid_o}, 32'h0);
        chk("redir_inst_kept", inst_o, 32'h0000_0013);

        // redirect squashes a held instruction
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0010_0093;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("h2_valid", {31'h0, inst_valid_o}, 32'h1);
        chk("h2_pc", inst_pc_o, 32'h8000_0100);
        chk("h2_inst", inst_o, 32'h0010_0093);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0200;
        inst_ready_i     = 1'b1;
        tick();
        redirect_valid_i = 1'b0;
        inst_ready_i     = 1'b0;
        chk("squash_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("squash_req", {31'h0, imem_req_valid_o}, 32'h1);
        chk("squash_addr", imem_req_addr_o, 32'h8000_0200);

        // redirect in REQ without handshake, then wrap past top
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFE;
        tick();
        redirect_valid_i = 1'b0;
        chk("wrap_req", {31'h0, imem_req_valid_o}, 32'h1);
        chk("wrap_addr", imem_req_addr_o, 32'hFFFF_FFFC);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0000_0013;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("wrap_inst_pc", inst_pc_o, 32'hFFFF_FFFC);
        chk("wrap_next", imem_req_addr_o, 32'h0000_0000);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk("wrap_req2", {31'h0, imem_req_valid_o}, 32'h1);
        chk("wrap_addr2", imem_req_addr_o, 32'h0000_0000);

        // redirect coinciding with handshake goes to DROP
        imem_req_ready_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0300;
        tick();
        imem_req_ready_i = 1'b0;
        redirect_valid_i = 1'b0;
        chk("hsr_drop_req", {31'h0, imem_req_valid_o}, 32'h0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h1234_5678;
        tick();
        chk("hsr_req", {31'h0, imem_req_valid_o}, 32'h1);
        chk("hsr_addr", imem_req_addr_o, 32'h8000_0300);
        chk("hsr_inst_valid", {31'h0, inst_valid_o}, 32'h0);

        // a response arriving in REQ is ignored
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("ign_req", {31'h0, imem_req_valid_o}, 32'h1);
        chk("ign_addr", imem_req_addr_o, 32'h8000_0300);
        chk("ign_inst_valid", {31'h0, inst_valid_o}, 32'h0);

        // asynchronous reset mid-transaction
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'h0, imem_req_valid_o}, 32'h0);
        chk("arst_inst_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("arst_inst", inst_o, 32'h0);
        chk("arst_inst_pc", inst_pc_o, 32'h0);
        chk("arst_addr", imem_req_addr_o, 32'h8000_0000);
        tick();
        rst_n = 1'b1;
        chk("post_idle", {31'h0, imem_req_valid_o}, 32'h0);
        tick();
        chk("post_req", {31'h0, imem_req_valid_o}, 32'h1);
        chk("post_addr", imem_req_addr_o, 32'h8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
